// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a bus-readable data register and sticky status flags.
// Optional even-parity bit is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        req_i,
  input  logic        we_i,
  input  logic        IN_i,
  output logic [31:0] DATA_o,
  output logic        valid_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        parity_err_o
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  // The IDLE->START transition already consumes one cycle of the start bit
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    data_reg, data_next;
  logic          valid_reg, valid_next;
  logic          frame_reg, frame_next;
  logic          overrun_reg, overrun_next;
  logic          brk_reg, brk_next;
  logic          sync_reg, rx_reg;
  logic          rd, byte_done, frame_set;

  assign rd = req_i & ~we_i;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync_reg <= 1'b1;
      rx_reg   <= 1'b1;
    end else begin
      sync_reg <= IN_i;
      rx_reg   <= sync_reg;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_reg, parity_next, parity_set;
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) parity_reg <= 1'b0;
    else       parity_reg <= parity_next;
  end
  always_comb begin
    parity_next = parity_reg & ~rd;
    if (parity_set) parity_next = 1'b1;
  end
  assign parity_err_o = parity_reg;
`else
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      frame_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      brk_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      frame_reg   <= frame_next;
      overrun_reg <= overrun_next;
      brk_reg     <= brk_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg + TIMER_ONE;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    brk_next     = brk_reg;
    byte_done    = 1'b0;
    frame_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_set   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        timer_next   = '0;
        bit_cnt_next = '0;
        if (!rx_reg) state_next = START;
      end
      START: begin
        if (timer_reg == HALF_LAST) begin
          timer_next = '0;
          state_next = rx_reg ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_reg == BIT_LAST) begin
          timer_next   = '0;
          shift_next   = {rx_reg, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
`else
          if (bit_cnt_reg == 3'd7) state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (timer_reg == BIT_LAST) begin
          timer_next = '0;
          parity_set = (^shift_reg) != rx_reg;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (brk_reg) begin
          // Line held low past the stop bit: wait for it to return idle
          timer_next = '0;
          if (rx_reg) begin
            brk_next   = 1'b0;
            state_next = IDLE;
          end
        end else if (timer_reg == BIT_LAST) begin
          timer_next = '0;
          if (rx_reg) begin
            byte_done  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_set = 1'b1;
            brk_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read clears status; any set landing on the same edge takes priority
  always_comb begin
    data_next    = data_reg;
    valid_next   = valid_reg & ~rd;
    frame_next   = frame_reg & ~rd;
    overrun_next = overrun_reg & ~rd;
    if (byte_done) begin
      if (!valid_reg || rd) begin
        data_next  = shift_reg;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
    if (frame_set) frame_next = 1'b1;
  end

  assign DATA_o      = {24'b0, data_reg};
  assign valid_o     = valid_reg;
  assign frame_err_o = frame_reg;
  assign overrun_o   = overrun_reg;

endmodule
